// File: rtl/mst_fifo_arbiter_pkg.sv
// rtl/mst_fifo_arbiter_pkg.sv - shared types and constants for the master-FIFO arbiter
package mst_fifo_arbiter_pkg;

  localparam int unsigned WORD_W  = 18;
  localparam int unsigned SOP_BIT = 17;
  localparam int unsigned EOP_BIT = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Header opcodes carried in payload[15:12] of a command's first word.
  typedef enum logic [3:0] {
    HDR_OP_MWR    = 4'h1,
    HDR_OP_STATUS = 4'h2,
    HDR_OP_CPL    = 4'h3
  } hdr_op_e;

endpackage

// File: rtl/mst_src_port.sv
// rtl/mst_src_port.sv - per-source read issue, return tracking and park register
module mst_src_port
  import mst_fifo_arbiter_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  word_t dout_i,
  input  logic  empty_i,
  input  logic  active_i,
  input  logic  full_i,
  input  logic  park_clr_i,
  output logic  rd_en_o,
  output logic  eligible_o,
  output logic  ret_valid_o,
  output word_t ret_data_o,
  output logic  park_valid_o,
  output word_t park_data_o
);

  logic  ret_valid_q;
  logic  park_valid_q;
  word_t park_data_q;

  assign rd_en_o      = active_i & ~empty_i & ~full_i;
  assign eligible_o   = park_valid_q | ~empty_i;
  assign ret_valid_o  = ret_valid_q;
  assign ret_data_o   = dout_i;
  assign park_valid_o = park_valid_q;
  assign park_data_o  = park_data_q;

  // A word returning after the grant ended is the over-read head of the next command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ret_valid_q  <= 1'b0;
      park_valid_q <= 1'b0;
      park_data_q  <= '0;
    end else begin
      ret_valid_q <= rd_en_o;
      if (ret_valid_q && !active_i) begin
        park_valid_q <= 1'b1;
        park_data_q  <= dout_i;
      end else if (park_clr_i) begin
        park_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mst_fifo_arbiter.sv
// rtl/mst_fifo_arbiter.sv - packet-level arbiter draining two command FIFOs into the master FIFO
module mst_fifo_arbiter
  import mst_fifo_arbiter_pkg::*;
#(
  parameter bit          PRIO_MODE = 1'b0,
  parameter int unsigned MAX_WORDS = 40
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  input  logic [WORD_W-1:0] src0_dout_i,
  input  logic              src0_empty_i,
  output logic              src0_rd_en_o,
  input  logic [WORD_W-1:0] src1_dout_i,
  input  logic              src1_empty_i,
  output logic              src1_rd_en_o,
  output logic [WORD_W-1:0] mst_din_o,
  output logic              mst_wr_en_o,
  input  logic              mst_full_i,
  output logic [7:0]        pkt_cnt0_o,
  output logic [7:0]        pkt_cnt1_o,
  output logic              err_sop_o,
  output logic              err_len_o,
  output logic              busy_o
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_WORDS);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       need_sop_q, need_sop_d;
  logic [5:0] word_cnt_q, word_cnt_d;
  word_t      mst_din_q, mst_din_d;
  logic       mst_wr_en_q, mst_wr_en_d;
  logic [7:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [7:0] pkt_cnt1_q, pkt_cnt1_d;
  logic       err_sop_q, err_sop_d;
  logic       err_len_q, err_len_d;

  logic [1:0] empty, active, rd_en, elig, ret_valid, park_valid, park_clr;
  word_t      dout      [2];
  word_t      ret_data  [2];
  word_t      park_data [2];
  word_t      word;
  logic       word_valid;

  assign empty   = {src1_empty_i, src0_empty_i};
  assign dout[0] = src0_dout_i;
  assign dout[1] = src1_dout_i;

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign active[i] = (state_q == ARB_XFER) && (grant_q == 1'(i));

    mst_src_port u_port (
      .clk_i        (sys_clk_i),
      .rst_ni       (sys_rst_n_i),
      .dout_i       (dout[i]),
      .empty_i      (empty[i]),
      .active_i     (active[i]),
      .full_i       (mst_full_i),
      .park_clr_i   (park_clr[i]),
      .rd_en_o      (rd_en[i]),
      .eligible_o   (elig[i]),
      .ret_valid_o  (ret_valid[i]),
      .ret_data_o   (ret_data[i]),
      .park_valid_o (park_valid[i]),
      .park_data_o  (park_data[i])
    );
  end

  // The parked word can only be present in the first cycle of a grant, never alongside a return.
  assign word_valid = park_valid[grant_q] | ret_valid[grant_q];
  assign word       = park_valid[grant_q] ? park_data[grant_q] : ret_data[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    need_sop_d   = need_sop_q;
    word_cnt_d   = word_cnt_q;
    mst_din_d    = mst_din_q;
    mst_wr_en_d  = 1'b0;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    err_sop_d    = err_sop_q;
    err_len_d    = err_len_q;
    park_clr     = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (|elig) begin
          state_d    = ARB_XFER;
          need_sop_d = 1'b1;
          word_cnt_d = '0;
          if (&elig) grant_d = PRIO_MODE ? 1'b0 : ~last_grant_q;
          else       grant_d = elig[1];
        end
      end
      ARB_XFER: begin
        if (word_valid) begin
          park_clr[grant_q] = park_valid[grant_q];
          if (need_sop_q && !word[SOP_BIT]) begin
            err_sop_d = 1'b1;
          end else begin
            need_sop_d  = 1'b0;
            mst_wr_en_d = 1'b1;
            mst_din_d   = word;
            if (word[EOP_BIT] || word_cnt_q == MAX_CNT) begin
              mst_din_d[EOP_BIT] = 1'b1;
              state_d            = ARB_IDLE;
              last_grant_d       = grant_q;
              if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 8'd1;
              else         pkt_cnt0_d = pkt_cnt0_q + 8'd1;
            end else begin
              word_cnt_d = word_cnt_q + 6'd1;
              if (word_cnt_d == MAX_CNT) err_len_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      need_sop_q   <= 1'b1;
      word_cnt_q   <= '0;
      mst_din_q    <= '0;
      mst_wr_en_q  <= 1'b0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      err_sop_q    <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      need_sop_q   <= need_sop_d;
      word_cnt_q   <= word_cnt_d;
      mst_din_q    <= mst_din_d;
      mst_wr_en_q  <= mst_wr_en_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      err_sop_q    <= err_sop_d;
      err_len_q    <= err_len_d;
    end
  end

  assign src0_rd_en_o = rd_en[0];
  assign src1_rd_en_o = rd_en[1];
  assign mst_din_o    = mst_din_q;
  assign mst_wr_en_o  = mst_wr_en_q;
  assign pkt_cnt0_o   = pkt_cnt0_q;
  assign pkt_cnt1_o   = pkt_cnt1_q;
  assign err_sop_o    = err_sop_q;
  assign err_len_o    = err_len_q;
  assign busy_o       = (state_q == ARB_XFER);

endmodule

// File: tb/tb_mst_fifo_arbiter.sv
// tb/tb_mst_fifo_arbiter.sv - self-checking bench for mst_fifo_arbiter
module tb_mst_fifo_arbiter;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [17:0] src0_dout, src1_dout, mst_din;
  logic        src0_empty, src1_empty, src0_rd_en, src1_rd_en;
  logic        mst_wr_en, mst_full;
  logic [7:0]  pkt_cnt0, pkt_cnt1;
  logic        err_sop, err_len, busy;

  mst_fifo_arbiter #(.PRIO_MODE(1'b0), .MAX_WORDS(40)) dut (
    .sys_clk_i    (sys_clk),
    .sys_rst_n_i  (sys_rst_n),
    .src0_dout_i  (src0_dout),
    .src0_empty_i (src0_empty),
    .src0_rd_en_o (src0_rd_en),
    .src1_dout_i  (src1_dout),
    .src1_empty_i (src1_empty),
    .src1_rd_en_o (src1_rd_en),
    .mst_din_o    (mst_din),
    .mst_wr_en_o  (mst_wr_en),
    .mst_full_i   (mst_full),
    .pkt_cnt0_o   (pkt_cnt0),
    .pkt_cnt1_o   (pkt_cnt1),
    .err_sop_o    (err_sop),
    .err_len_o    (err_len),
    .busy_o       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          src;
    int          nwords;
    logic [15:0] base;
    logic [7:0]  exp_cnt0;
    logic [7:0]  exp_cnt1;
  } vec_t;

  logic [17:0] src0_q[$];
  logic [17:0] src1_q[$];
  logic [17:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_count = 0;
  logic        rd0_s = 1'b0;
  logic        rd1_s = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] mk_word(input int k, input int n, input bit sop, input bit eop,
                                          input logic [15:0] base);
    logic [17:0] w;
    w[17]   = sop && (k == 0);
    w[16]   = eop && (k == n - 1);
    w[15:0] = base + 16'(k);
    return w;
  endfunction

  function automatic logic [63:0] outs();
    return {24'b0, src0_rd_en, src1_rd_en, mst_din, mst_wr_en, pkt_cnt0, pkt_cnt1,
            err_sop, err_len, busy};
  endfunction

  task automatic refresh_empty();
    src0_empty = (src0_q.size() == 0);
    src1_empty = (src1_q.size() == 0);
  endtask

  task automatic push_cmd(input int s, input int n, input bit eop, input logic [15:0] base,
                          input bit expect_it);
    for (int k = 0; k < n; k++) begin
      if (s == 0) src0_q.push_back(mk_word(k, n, 1'b1, eop, base));
      else        src1_q.push_back(mk_word(k, n, 1'b1, eop, base));
      if (expect_it) exp_q.push_back(mk_word(k, n, 1'b1, eop, base));
    end
    refresh_empty();
  endtask

  task automatic expect_cmd(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) exp_q.push_back(mk_word(k, n, 1'b1, 1'b1, base));
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge sys_clk);
      #1;
      done = (exp_q.size() == 0) && !busy && (src0_q.size() == 0) && (src1_q.size() == 0);
    end
    check(name, 64'(done), 64'd1);
  endtask

  // Master-FIFO side: every write is popped against the scoreboard.
  always @(negedge sys_clk) begin
    rd0_s = src0_rd_en;
    rd1_s = src1_rd_en;
    if (sys_rst_n && mst_wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got %05h, expected no write", mst_din);
      end else begin
        check("mst_din", 64'(mst_din), 64'(exp_q.pop_front()));
      end
    end
  end

  // Source FIFO models: a read in one cycle presents data in the next.
  always @(posedge sys_clk) begin
    #1;
    if (rd0_s && src0_q.size() > 0) src0_dout = src0_q.pop_front();
    if (rd1_s && src1_q.size() > 0) src1_dout = src1_q.pop_front();
    refresh_empty();
  end

  initial begin
    vec_t vecs[4];
    int   wc, snap;
    bit   reached, rd_bad;
    logic [17:0] w;

    vecs[0] = '{0, 35, 16'h0100, 8'd1, 8'd0};
    vecs[1] = '{1,  4, 16'h0200, 8'd1, 8'd1};
    vecs[2] = '{0,  1, 16'h0300, 8'd2, 8'd1};
    vecs[3] = '{1, 40, 16'h0400, 8'd2, 8'd2};

    sys_rst_n = 1'b0;
    mst_full  = 1'b0;
    src0_dout = '0;
    src1_dout = '0;
    refresh_empty();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outs", outs(), 64'd0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    foreach (vecs[i]) begin
      wc = wr_count;
      @(posedge sys_clk);
      #1 push_cmd(vecs[i].src, vecs[i].nwords, 1'b1, vecs[i].base, 1'b1);
      wait_drain($sformatf("vec%0d_drain", i), 200);
      check($sformatf("vec%0d_writes", i), 64'(wr_count - wc), 64'(vecs[i].nwords));
      check($sformatf("vec%0d_cnt0", i), 64'(pkt_cnt0), 64'(vecs[i].exp_cnt0));
      check($sformatf("vec%0d_cnt1", i), 64'(pkt_cnt1), 64'(vecs[i].exp_cnt1));
      check($sformatf("vec%0d_errs", i), 64'({err_sop, err_len}), 64'd0);
    end

    // Round-robin with two commands per source; the over-read heads get parked.
    wc = wr_count;
    @(posedge sys_clk);
    #1;
    push_cmd(0, 4, 1'b1, 16'h1000, 1'b0);
    push_cmd(0, 4, 1'b1, 16'h1100, 1'b0);
    push_cmd(1, 4, 1'b1, 16'h2000, 1'b0);
    push_cmd(1, 4, 1'b1, 16'h2100, 1'b0);
    expect_cmd(4, 16'h1000);
    expect_cmd(4, 16'h2000);
    expect_cmd(4, 16'h1100);
    expect_cmd(4, 16'h2100);
    wait_drain("rr_drain", 300);
    check("rr_writes", 64'(wr_count - wc), 64'd16);
    check("rr_cnt0", 64'(pkt_cnt0), 64'd4);
    check("rr_cnt1", 64'(pkt_cnt1), 64'd4);

    wc = wr_count;
    @(posedge sys_clk);
    #1;
    push_cmd(0, 4, 1'b1, 16'h3000, 1'b1);
    push_cmd(0, 4, 1'b1, 16'h3100, 1'b1);
    wait_drain("b2b_drain", 200);
    check("b2b_writes", 64'(wr_count - wc), 64'd8);
    check("b2b_cnt0", 64'(pkt_cnt0), 64'd6);

    // Back-pressure mid-command.
    wc = wr_count;
    @(posedge sys_clk);
    #1 push_cmd(0, 20, 1'b1, 16'h4000, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge sys_clk);
      #1 reached = (wr_count - wc) >= 5;
    end
    check("full_start", 64'(reached), 64'd1);
    @(posedge sys_clk);
    #1 mst_full = 1'b1;
    @(posedge sys_clk);
    #2 snap = wr_count;
    rd_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      rd_bad = rd_bad | src0_rd_en | src1_rd_en;
    end
    @(posedge sys_clk);
    #1 mst_full = 1'b0;
    check("full_rd_en", 64'(rd_bad), 64'd0);
    check("full_inflight", 64'((wr_count - snap) <= 1), 64'd1);
    wait_drain("full_drain", 200);
    check("full_writes", 64'(wr_count - wc), 64'd20);
    check("full_cnt0", 64'(pkt_cnt0), 64'd7);

    // First source-1 word lacks SOP and must be dropped.
    wc = wr_count;
    @(posedge sys_clk);
    #1;
    src1_q.push_back(18'h01234);
    push_cmd(1, 3, 1'b1, 16'h6000, 1'b1);
    wait_drain("nosop_drain", 200);
    check("nosop_err_sop", 64'(err_sop), 64'd1);
    check("nosop_writes", 64'(wr_count - wc), 64'd3);
    check("nosop_cnt1", 64'(pkt_cnt1), 64'd5);

    // Over-length command: word 40 is written with EOP forced.
    wc = wr_count;
    @(posedge sys_clk);
    #1;
    push_cmd(0, 45, 1'b0, 16'h7000, 1'b0);
    for (int k = 0; k <= 40; k++) begin
      w = mk_word(k, 45, 1'b1, 1'b0, 16'h7000);
      if (k == 40) w[16] = 1'b1;
      exp_q.push_back(w);
    end
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge sys_clk);
      #1 reached = (exp_q.size() == 0);
    end
    check("len_drain", 64'(reached), 64'd1);
    check("len_err_len", 64'(err_len), 64'd1);
    check("len_cnt0", 64'(pkt_cnt0), 64'd8);
    repeat (12) @(negedge sys_clk);
    check("len_writes", 64'(wr_count - wc), 64'd41);
    check("len_resync_busy", 64'(busy), 64'd1);

    @(posedge sys_clk);
    #1 push_cmd(0, 10, 1'b0, 16'h8000, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      @(negedge sys_clk);
      #1 reached = (exp_q.size() <= 7);
    end
    check("resync_fwd", 64'(reached), 64'd1);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 check("async_reset_outs", outs(), 64'd0);
    exp_q.delete();
    src0_q.delete();
    src1_q.delete();
    refresh_empty();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_hold_outs", outs(), 64'd0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // After reset source 0 must win a simultaneous request.
    wc = wr_count;
    @(posedge sys_clk);
    #1;
    push_cmd(0, 2, 1'b1, 16'h9000, 1'b1);
    push_cmd(1, 2, 1'b1, 16'hA000, 1'b1);
    wait_drain("post_reset_drain", 100);
    check("post_reset_writes", 64'(wr_count - wc), 64'd4);
    check("post_reset_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'h0101);
    check("post_reset_errs", 64'({err_sop, err_len}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
